spi_slave_buf: RTL and testbench

- SPI responder (target) side of the flash-style byte protocol that the USB SPI bridge drives as initiator.
- Lets an external SPI master write to and read from a 64-byte dual-access buffer, and read a status byte supplied by fabric.
- Fabric logic (USB endpoint side) reads and writes the same buffer through a local port and is notified when an SPI write burst completes.
- SPI signals are oversampled in the clk domain; there is no SPI-clocked logic.

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_slave_buf_if.sv | 28 ++
 rtl/spi_slave_sync.sv | 49 ++++
 rtl/spi_slave_buf.sv | 145 ++++++++++++++
 tb/tb_spi_slave_buf.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared command codes, FSM state type and default buffer geometry for the
// SPI responder buffer.
package spi_slave_pkg;

  localparam int unsigned BUF_AW_DEF = 6;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_STAT,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_slave_buf_if.sv
// Fabric-side port of the SPI buffer: local RAM access, status byte and
// write-burst completion report.
interface spi_slave_buf_if
  import spi_slave_pkg::*;
#(
  parameter int unsigned BUF_AW = BUF_AW_DEF
);

  logic [BUF_AW-1:0] loc_addr;
  logic              loc_we;
  logic [7:0]        loc_wdata;
  logic [7:0]        loc_rdata;
  logic [7:0]        status_in;
  logic              wr_done;
  logic [BUF_AW-1:0] wr_start;
  logic [BUF_AW:0]   wr_len;

  modport master (
    output loc_addr, loc_we, loc_wdata, status_in,
    input  loc_rdata, wr_done, wr_start, wr_len
  );

  modport slave (
    input  loc_addr, loc_we, loc_wdata, status_in,
    output loc_rdata, wr_done, wr_start, wr_len
  );

endinterface

// File: rtl/spi_slave_sync.sv
// Synchronizes the raw SPI pins into the clk domain and produces single-cycle
// rise/fall pulses for spi_clk and spi_csn.
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_csn,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_s,
  output logic csn_rise,
  output logic csn_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sh, csn_sh, mosi_sh;
  logic                   sclk_q, csn_q;
  logic                   sclk_s;

  // csn chain resets low so a select held through reset never yields a fall
  // until the pin has first been seen high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sh <= '1;
      csn_sh  <= '0;
      mosi_sh <= '0;
      sclk_q  <= 1'b1;
      csn_q   <= 1'b0;
    end else begin
      sclk_sh <= {sclk_sh[SYNC_STAGES-2:0], spi_clk};
      csn_sh  <= {csn_sh[SYNC_STAGES-2:0], spi_csn};
      mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], spi_mosi};
      sclk_q  <= sclk_s;
      csn_q   <= csn_s;
    end
  end

  assign sclk_s    = sclk_sh[SYNC_STAGES-1];
  assign csn_s     = csn_sh[SYNC_STAGES-1];
  assign mosi_s    = mosi_sh[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign csn_rise  = csn_s & ~csn_q;
  assign csn_fall  = ~csn_s & csn_q;

endmodule

// File: rtl/spi_slave_buf.sv
// Mode-3 SPI responder in front of a dual-access byte buffer; the SPI pins are
// oversampled, so all logic runs on clk.
module spi_slave_buf
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUF_AW      = BUF_AW_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            spi_clk,
  input  logic            spi_csn,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  spi_slave_buf_if.slave  loc
);

  localparam logic [BUF_AW:0] LEN_MAX = {1'b1, {BUF_AW{1'b0}}};

  logic sclk_rise, sclk_fall, csn_s, csn_rise, csn_fall, mosi_s;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .csn_s     (csn_s),
    .csn_rise  (csn_rise),
    .csn_fall  (csn_fall),
    .mosi_s    (mosi_s)
  );

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        sh_in;
  logic [7:0]        sh_out;
  logic [BUF_AW-1:0] addr, start_addr;
  logic [BUF_AW:0]   wlen_cnt;
  logic [7:0]        stat_q;
  logic              is_write;
  logic              armed;
  logic [7:0]        rd_buf;
  logic [7:0]        rx_byte;
  logic              byte_done, spi_we;
  logic [7:0]        mem [2**BUF_AW];

  assign rx_byte   = {sh_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign spi_we    = byte_done && (state == ST_WDATA) && !csn_rise;
  assign spi_miso  = sh_out[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      sh_in        <= '0;
      sh_out       <= '1;
      addr         <= '0;
      start_addr   <= '0;
      wlen_cnt     <= '0;
      stat_q       <= '0;
      is_write     <= 1'b0;
      armed        <= 1'b0;
      spi_miso_oe  <= 1'b0;
      loc.wr_done  <= 1'b0;
      loc.wr_start <= '0;
      loc.wr_len   <= '0;
    end else begin
      loc.wr_done <= 1'b0;
      if (csn_s) armed <= 1'b1;
      spi_miso_oe <= armed & ~csn_s;

      if (csn_rise) begin
        if (state == ST_WDATA && wlen_cnt != '0) begin
          loc.wr_done  <= 1'b1;
          loc.wr_start <= start_addr;
          loc.wr_len   <= wlen_cnt;
        end
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sh_out  <= '1;
      end else if (csn_fall && state == ST_IDLE) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
        sh_out  <= '1;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          sh_in   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            unique case (state)
              ST_CMD: begin
                case (rx_byte)
                  CMD_WRITE:  begin state <= ST_ADDR; is_write <= 1'b1; end
                  CMD_READ:   begin state <= ST_ADDR; is_write <= 1'b0; end
                  CMD_STATUS: begin state <= ST_STAT; stat_q <= loc.status_in; end
                  default:    state <= ST_IGNORE;
                endcase
              end
              ST_ADDR: begin
                addr       <= rx_byte[BUF_AW-1:0];
                start_addr <= rx_byte[BUF_AW-1:0];
                wlen_cnt   <= '0;
                state      <= is_write ? ST_WDATA : ST_RDATA;
              end
              ST_WDATA: begin
                addr <= addr + 1'b1;
                if (wlen_cnt != LEN_MAX) wlen_cnt <= wlen_cnt + 1'b1;
              end
              default: ;
            endcase
          end
        end else if (sclk_fall) begin
          // A fall with the counter at zero opens a new byte: load, don't shift.
          if (bit_cnt == 3'd0) begin
            unique case (state)
              ST_RDATA: begin sh_out <= rd_buf; addr <= addr + 1'b1; end
              ST_STAT:  sh_out <= stat_q;
              default:  sh_out <= '1;
            endcase
          end else begin
            sh_out <= {sh_out[6:0], 1'b1};
          end
        end
      end
    end
  end

  // SPI write is issued after the local one so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (loc.loc_we) mem[loc.loc_addr] <= loc.loc_wdata;
    if (spi_we)     mem[addr]         <= rx_byte;
    rd_buf <= mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loc.loc_rdata <= '0;
    else          loc.loc_rdata <= mem[loc.loc_addr];
  end

endmodule

// File: tb/tb_spi_slave_buf.sv
// Directed + randomized bench for spi_slave_buf against a byte-array model of
// the buffer and burst-completion reporting.
module tb_spi_slave_buf;
  import spi_slave_pkg::*;

  localparam int unsigned SS    = 2;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned HALF  = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_clk = 1'b1;
  logic spi_csn = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;

  spi_slave_buf_if #(.BUF_AW(AW)) bus();

  spi_slave_buf #(.SYNC_STAGES(SS), .BUF_AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_clk     (spi_clk),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .loc         (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned    done_cnt = 0;
  logic [AW-1:0]  last_start = '0;
  logic [AW:0]    last_len = '0;
  logic [7:0]     mdl [DEPTH];

  logic           coll_en = 1'b0;
  logic [AW-1:0]  coll_addr = '0;
  logic [7:0]     coll_data = '0;
  logic [7:0]     coll_old;

  always @(negedge clk) begin
    if (bus.wr_done === 1'b1) begin
      done_cnt++;
      last_start = bus.wr_start;
      last_len   = bus.wr_len;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus.loc_addr = a; bus.loc_wdata = d; bus.loc_we = 1'b1;
    wait_clk(1);
    bus.loc_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic loc_read(input logic [AW-1:0] a, output logic [7:0] d);
    bus.loc_addr = a;
    wait_clk(1);
    d = bus.loc_rdata;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int unsigned i = 0; i < nbits; i++) begin
      spi_clk = 1'b0; spi_mosi = tx[7-i];
      wait_clk(HALF);
      rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      if (coll_en && i == nbits - 1) begin
        // land the local write in the same clk as the SPI byte commit
        wait_clk(2);
        bus.loc_addr = coll_addr; bus.loc_wdata = coll_data; bus.loc_we = 1'b1;
        wait_clk(1);
        coll_old = bus.loc_rdata;
        bus.loc_we = 1'b0;
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
    end
  endtask

  task automatic spi_txn(input logic [7:0] tx[$], output logic [7:0] rx[$]);
    logic [7:0] b;
    rx = {};
    spi_csn = 1'b0;
    wait_clk(4);
    foreach (tx[k]) begin
      spi_byte(tx[k], 8, b);
      rx.push_back(b);
    end
    wait_clk(2);
    spi_csn = 1'b1;
    wait_clk(8);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int unsigned n, input string tag);
    logic [7:0] tx[$], rx[$], ab;
    int unsigned dc0;
    int unsigned exp_len;
    ab = 8'($urandom);
    ab[AW-1:0] = a;
    tx = {CMD_WRITE, ab};
    for (int unsigned i = 0; i < n; i++) tx.push_back(8'($urandom));
    dc0 = done_cnt;
    spi_txn(tx, rx);
    for (int unsigned i = 0; i < n; i++) mdl[(int'(a) + i) % DEPTH] = tx[2+i];
    exp_len = (n > DEPTH) ? DEPTH : n;
    chk({tag, "_done_cnt"}, done_cnt - dc0, 1);
    chk({tag, "_start"}, last_start, a);
    chk({tag, "_len"}, last_len, exp_len);
  endtask

  task automatic check_read(input logic [AW-1:0] a, input int unsigned n, input string tag);
    logic [7:0] tx[$], rx[$], ab;
    ab = 8'($urandom);
    ab[AW-1:0] = a;
    tx = {CMD_READ, ab};
    for (int unsigned i = 0; i < n; i++) tx.push_back(8'($urandom));
    spi_txn(tx, rx);
    chk({tag, "_cmd_ff"}, rx[0], 8'hFF);
    chk({tag, "_addr_ff"}, rx[1], 8'hFF);
    for (int unsigned i = 0; i < n; i++)
      chk({tag, "_data"}, rx[2+i], mdl[(int'(a) + i) % DEPTH]);
  endtask

  initial begin
    logic [7:0] tx[$], rx[$];
    logic [7:0] d, b, old20, sdat;
    logic [AW-1:0] ra;
    int unsigned dc0, cnt;

    bus.loc_addr = '0; bus.loc_we = 1'b0; bus.loc_wdata = '0; bus.status_in = '0;

    wait_clk(3);
    chk("rst_miso", spi_miso, 1'b1);
    chk("rst_oe", spi_miso_oe, 1'b0);
    chk("rst_rdata", bus.loc_rdata, 8'h00);
    chk("rst_wr_done", bus.wr_done, 1'b0);
    chk("rst_wr_start", bus.wr_start, 0);
    chk("rst_wr_len", bus.wr_len, 0);

    reset_n = 1'b1;
    wait_clk(10);
    for (int unsigned a = 0; a < DEPTH; a++) loc_write(AW'(a), 8'($urandom));

    // fixed write 02 10 AA BB CC
    dc0 = done_cnt;
    tx = {CMD_WRITE, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    spi_txn(tx, rx);
    mdl[16] = 8'hAA; mdl[17] = 8'hBB; mdl[18] = 8'hCC;
    chk("wr1_done_cnt", done_cnt - dc0, 1);
    chk("wr1_start", last_start, 6'h10);
    chk("wr1_len", last_len, 3);
    chk("wr1_start_hold", bus.wr_start, 6'h10);
    loc_read(6'h10, d); chk("wr1_buf10", d, 8'hAA);
    loc_read(6'h11, d); chk("wr1_buf11", d, 8'hBB);
    loc_read(6'h12, d); chk("wr1_buf12", d, 8'hCC);

    // wrap-around read
    loc_write(6'h3E, 8'h11);
    loc_write(6'h3F, 8'h22);
    loc_write(6'h00, 8'h33);
    tx = {CMD_READ, 8'h3E, 8'h00, 8'h00, 8'h00};
    spi_txn(tx, rx);
    chk("rdwrap_0", rx[0], 8'hFF);
    chk("rdwrap_1", rx[1], 8'hFF);
    chk("rdwrap_2", rx[2], 8'h11);
    chk("rdwrap_3", rx[3], 8'h22);
    chk("rdwrap_4", rx[4], 8'h33);

    // status latched at command completion
    bus.status_in = 8'h5A;
    spi_csn = 1'b0; wait_clk(4);
    spi_byte(CMD_STATUS, 8, b); chk("stat_cmd", b, 8'hFF);
    spi_byte(8'h00, 8, b);      chk("stat_b1", b, 8'h5A);
    bus.status_in = 8'hA5 ^ 8'($urandom_range(1, 255));
    spi_byte(8'h00, 8, b);      chk("stat_b2", b, 8'h5A);
    wait_clk(2); spi_csn = 1'b1; wait_clk(8);

    // aborted partial byte: no write, no pulse
    dc0 = done_cnt;
    old20 = mdl[32];
    spi_csn = 1'b0; wait_clk(4);
    spi_byte(CMD_WRITE, 8, b);
    spi_byte(8'h20, 8, b);
    spi_byte(~old20, 4, b);
    wait_clk(2); spi_csn = 1'b1; wait_clk(8);
    chk("part_no_done", done_cnt - dc0, 0);
    loc_read(6'h20, d); chk("part_buf20", d, old20);

    // unknown command plus chip-select to output-enable latency
    dc0 = done_cnt;
    chk("oe_before", spi_miso_oe, 1'b0);
    spi_csn = 1'b0;
    cnt = 0;
    while (spi_miso_oe !== 1'b1 && cnt < 20) begin wait_clk(1); cnt++; end
    chk("oe_on_lat", cnt, SS + 1);
    wait_clk(2);
    spi_byte(8'h9F, 8, b); chk("ign_cmd", b, 8'hFF);
    for (int unsigned i = 0; i < 3; i++) begin
      spi_byte(8'($urandom), 8, b); chk("ign_data", b, 8'hFF);
    end
    wait_clk(2);
    spi_csn = 1'b1;
    cnt = 0;
    while (spi_miso_oe !== 1'b0 && cnt < 20) begin wait_clk(1); cnt++; end
    chk("oe_off_lat", cnt, SS + 1);
    wait_clk(8);
    chk("ign_no_done", done_cnt - dc0, 0);
    for (int unsigned a = 0; a < 4; a++) begin
      loc_read(AW'(a * 16 + 5), d); chk("ign_buf", d, mdl[a * 16 + 5]);
    end

    // reset in the middle of a write burst
    dc0 = done_cnt;
    spi_csn = 1'b0; wait_clk(4);
    spi_byte(CMD_WRITE, 8, b);
    spi_byte(8'h30, 8, b);
    spi_byte(8'hAA, 8, b);
    mdl[48] = 8'hAA;
    spi_byte(8'h00, 3, b);
    wait_clk(2);
    reset_n = 1'b0;
    wait_clk(1);
    chk("mrst_miso", spi_miso, 1'b1);
    chk("mrst_oe", spi_miso_oe, 1'b0);
    chk("mrst_rdata", bus.loc_rdata, 8'h00);
    chk("mrst_wr_done", bus.wr_done, 1'b0);
    chk("mrst_wr_start", bus.wr_start, 0);
    chk("mrst_wr_len", bus.wr_len, 0);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(6);
    // select still low from before reset: traffic must be ignored
    spi_byte(CMD_WRITE, 8, b);
    spi_byte(8'h31, 8, b);
    spi_byte(~mdl[49], 8, b);
    wait_clk(2); spi_csn = 1'b1; wait_clk(8);
    chk("mrst_no_done", done_cnt - dc0, 0);
    loc_read(6'h30, d); chk("mrst_buf30", d, 8'hAA);
    loc_read(6'h31, d); chk("mrst_buf31", d, mdl[49]);
    ra = AW'($urandom);
    write_burst(ra, 3, "post_rst");
    check_read(ra, 3, "post_rst_rd");

    // same-cycle SPI and local write to one address
    ra = AW'($urandom);
    sdat = 8'($urandom);
    dc0 = done_cnt;
    spi_csn = 1'b0; wait_clk(4);
    spi_byte(CMD_WRITE, 8, b);
    spi_byte({2'b00, ra}, 8, b);
    coll_en = 1'b1; coll_addr = ra; coll_data = ~sdat;
    spi_byte(sdat, 8, b);
    coll_en = 1'b0;
    wait_clk(2); spi_csn = 1'b1; wait_clk(8);
    chk("coll_old_read", coll_old, mdl[ra]);
    mdl[ra] = sdat;
    loc_read(ra, d); chk("coll_spi_wins", d, sdat);
    chk("coll_len", last_len, 1);
    chk("coll_done_cnt", done_cnt - dc0, 1);

    // randomized bursts and SPI read-back
    for (int unsigned it = 0; it < 4; it++) begin
      ra = AW'($urandom);
      cnt = $urandom_range(1, 6);
      write_burst(ra, cnt, "rnd_wr");
      check_read(AW'($urandom), $urandom_range(1, 4), "rnd_rd");
      check_read(ra, cnt, "rnd_rdback");
    end

    // over-long burst: wraps and length saturates
    ra = AW'($urandom);
    write_burst(ra, DEPTH + 2, "sat");
    for (int unsigned a = 0; a < DEPTH; a++) begin
      loc_read(AW'(a), d); chk("sat_buf", d, mdl[a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
